// File: rtl/restoring_divider_4bit_pkg.sv
// restoring_divider_4bit_pkg: shared widths and FSM state encoding for the 4-bit restoring divider
package restoring_divider_4bit_pkg;
  localparam int DATA_W = 4;
  localparam int ITERS = DATA_W;
  localparam int CNT_W = $clog2(ITERS);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/restoring_divider_4bit_subtractor_5bit.sv
// subtractor_5bit: ripple-borrow subtractor, o_borrow set when i_a < i_b
module subtractor_5bit (
  input  logic [4:0] i_a,
  input  logic [4:0] i_b,
  output logic [4:0] o_diff,
  output logic       o_borrow
);
  logic [5:0] w_b;
  assign w_b[0] = 1'b0;
  for (genvar i = 0; i < 5; i++) begin : g_bit
    assign o_diff[i] = i_a[i] ^ i_b[i] ^ w_b[i];
    assign w_b[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_b[i]);
  end
  assign o_borrow = w_b[5];
endmodule

// File: rtl/restoring_divider_4bit.sv
// restoring_divider_4bit: sequential unsigned 4-bit restoring divider, one quotient bit per CALC cycle
module restoring_divider_4bit
  import restoring_divider_4bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] Dividend,
  input  logic [DATA_W-1:0] Divisor,
  output logic [DATA_W-1:0] Quotient,
  output logic [DATA_W-1:0] Remainder,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero
);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_dvd, r_dvs;
  logic [DATA_W:0]   r_part, w_shift, w_trial, w_part_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_q_next;
  logic              w_borrow;
  // r_dvd shifts dividend bits out the top while quotient bits enter at the bottom
  assign w_shift = (r_part << 1) | {{DATA_W{1'b0}}, r_dvd[DATA_W-1]};
  subtractor_5bit u_sub (
    .i_a(w_shift),
    .i_b({1'b0, r_dvs}),
    .o_diff(w_trial),
    .o_borrow(w_borrow)
  );
  assign w_part_next = w_borrow ? w_shift : w_trial;
  assign w_q_next = {r_dvd[DATA_W-2:0], ~w_borrow};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? ((Divisor == '0) ? DONE : CALC) : IDLE) :
             (r_state == CALC) ? ((r_cnt == '0) ? DONE : CALC) : IDLE;
  end
  always_comb begin
    busy = r_state != IDLE;
    done = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_part      <= '0;
      r_cnt       <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_dvd  <= Dividend;
      r_dvs  <= Divisor;
      r_part <= '0;
      r_cnt  <= CNT_W'(ITERS - 1);
      if (Divisor == '0) begin
        Quotient    <= '1;
        Remainder   <= Dividend;
        div_by_zero <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_part <= w_part_next;
      r_dvd  <= w_q_next;
      r_cnt  <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        Quotient    <= w_q_next;
        Remainder   <= w_part_next[DATA_W-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule

// File: doc/restoring_divider_4bit.md
RESTORING_DIVIDER_4BIT -- requirements
Module: restoring_divider_4bit

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: async active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division, sampled on clk.
REQ-005 The block SHALL have port Dividend, input, 4 bits: unsigned numerator, sampled with start.
REQ-006 The block SHALL have port Divisor, input, 4 bits: unsigned denominator, sampled with start.
REQ-007 The block SHALL have port Quotient, output, 4 bits: registered result.
REQ-008 The block SHALL have port Remainder, output, 4 bits: registered result.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: registered flag for the last result.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 In IDLE with start=1 and Divisor!=0, the block SHALL capture the operands, clear the 5-bit partial remainder, load the counter to 3 and go to CALC.
REQ-014 In IDLE with start=1 and Divisor==0, the block SHALL go directly to DONE with Quotient=4'hF, Remainder=Dividend and div_by_zero=1.
REQ-015 On each CALC cycle the block SHALL shift the partial remainder left and insert the current dividend MSB.
REQ-016 On each CALC cycle the block SHALL compute trial = R - {1'b0, Divisor}; no borrow means R=trial and q bit=1; borrow means R is kept and q bit=0.
REQ-017 CALC SHALL last exactly 4 cycles; on counter==0 the FSM SHALL go to DONE.
REQ-018 On entry to DONE the block SHALL load Quotient, Remainder and div_by_zero together; div_by_zero=0 for a nonzero divisor.
REQ-019 done SHALL be 1 only in DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-020 Latency SHALL be: done high 5 cycles after the start-sampling edge for a nonzero divisor, and 1 cycle for a zero divisor.
REQ-021 start SHALL be ignored outside IDLE, and operand changes during CALC SHALL have no effect.
REQ-022 Quotient, Remainder and div_by_zero SHALL hold their values until the next DONE entry.
REQ-023 Results SHALL satisfy Dividend == Quotient*Divisor + Remainder with Remainder < Divisor.

Reset
REQ-024 rst=1 SHALL immediately set state=IDLE and clear Quotient, Remainder, busy, done, div_by_zero, the counter and the working registers to 0.
REQ-025 Reset during CALC or DONE SHALL abort the operation with no done pulse, and the next start after rst deassertion SHALL be accepted normally.

Structure
REQ-026 The shared package SHALL hold the state enum (IDLE/CALC/DONE), the constant DATA_W=4, and the constant ITERS=DATA_W.
REQ-027 The trial subtraction SHALL be a sub-module subtractor_5bit: a ripple-borrow chain with a borrow-out port that is reused per iteration.

Verification
REQ-028 Dividend=13, Divisor=3, start -> done 5 cycles later, Quotient=4, Remainder=1, div_by_zero=0.
REQ-029 Dividend=15, Divisor=1 -> Quotient=15, Remainder=0; Dividend=2, Divisor=9 -> Quotient=0, Remainder=2.
REQ-030 Dividend=7, Divisor=0 -> done 1 cycle later, Quotient=4'hF, Remainder=7, div_by_zero=1.
REQ-031 A second start with different operands during CALC -> ignored; the first result is unchanged and busy stays high through DONE.
REQ-032 rst pulsed on the 2nd CALC cycle -> outputs 0, no done pulse; a new start with 9/2 -> Quotient=4, Remainder=1.
REQ-033 All 256 operand pairs run back-to-back -> each result matches REQ-023, or REQ-014 when Divisor==0.
